dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Two-port arbiter and sequencer in front of the single-port, word-indexed data memory. Port 0 serves the core load/store path and port 1 serves the program/data loader. Each beat is one read or one write, handed off with a valid/ready handshake. A round-robin arbiter with a bounded burst length shares the memory between the ports, rejects out-of-range indices with an error response, and returns read data one cycle after acceptance.

## Interface
- DEPTH, 1024: number of 32-bit words in the memory; valid indices are 0..DEPTH-1.
- MAX_BURST, 4: maximum consecutive beats an owner may take while the other port is waiting (≥1).

Ports:
- clk  in  1  single clock; all state changes on its rising edge.
- rst  in  1  synchronous, active-high reset.
- p0_valid / p1_valid  in  1  request present.
- p0_ready / p1_ready  out  1  request accepted this cycle (combinational grant).
- p0_we / p1_we  in  1  1 = write, 0 = read.
- p0_addr / p1_addr  in  32  word index.
- p0_wdata / p1_wdata  in  32  write data.
- p0_rsp_valid / p1_rsp_valid  out  1  response for the beat accepted last cycle.
- p0_rsp_err / p1_rsp_err  out  1  that beat was out of range.
- p0_rsp_rdata / p1_rsp_rdata  out  32  read data; 0 for writes and errors.
- mem_we  out  1  memory write enable.
- mem_addr  out  32  memory index.
- mem_wd  out  32  memory write data.
- mem_rd  in  32  combinational memory read data.

## Operation
- State: owner ∈ {IDLE, OWN0, OWN1}; burst counter cnt, width clog2(MAX_BURST+1), saturating at MAX_BURST; round-robin pointer rr (0 or 1).
- Grant, combinational, at most one port per cycle:
  - IDLE:
    - both valid → grant port rr;
    - only one valid → grant that port;
    - neither valid → no grant.
  - OWNk:
    - pk_valid and (cnt < MAX_BURST or !p(1-k)_valid) → grant k;
    - otherwise p(1-k)_valid → grant 1-k;
    - otherwise → no grant.
- pX_ready = grant to X. Accept = valid & ready.
- Update on accept by port k:
  - owner ← OWNk;
  - cnt ← (owner was OWNk) ? sat(cnt+1) : 1;
  - rr ← 1-k.
- Cycle with no accept: owner ← IDLE, cnt ← 0, rr unchanged.
- Range check: the beat is in range iff addr < DEPTH, using a full 32-bit unsigned compare.
- Memory drive:
  - mem_addr / mem_wd follow the granted port; with no grant they hold 0.
  - mem_we = accept & we & in_range.
  - Reads and out-of-range beats never assert mem_we.
- Response registers, loaded on the accept cycle:
  - rsp_valid ← 1 for the accepting port, 0 for the other;
  - err ← !in_range;
  - rdata ← (!we & in_range) ? mem_rd : 0.
- Responses cannot be back-pressured. A requester must sink rsp_valid the cycle it appears.

## Timing
- Reset (rst=1 at an edge) sets owner=IDLE, cnt=0, rr=0, and clears all rsp_valid, rsp_err and rsp_rdata.
- While rst is high, p0_ready, p1_ready and mem_we are forced to 0, so no beat is accepted and no write is issued.
- If reset is asserted the cycle after an accept, the pending response is dropped (rsp_valid=0). A write accepted before reset has already been committed.
- Write latency: data is in memory at the edge ending the accept cycle T. A read of the same index accepted at T+1 returns the new value.
- Read latency: a read accepted at T has rsp_valid and rdata valid during T+1.
- Throughput: one beat per cycle, with no bubble when ownership switches.
- Simultaneous first requests after reset go to port 0 (rr=0).
- Index DEPTH-1 is in range. DEPTH, and any index ≥ DEPTH including 0xFFFFFFFF, is an error; there is no wrap-around.
- Single-owner streaming: a lone requester may exceed MAX_BURST indefinitely, with cnt held at MAX_BURST.

## Test plan
- Reset, then a port-0 write of 0x00000020 to index 28 followed by a port-0 read of index 28:
  - mem_we=1 only on the write cycle;
  - rsp_valid=1 with rdata=0x00000020 one cycle after the read is accepted.
- Both ports valid continuously with MAX_BURST=4, port 0 granted first:
  - grant pattern 0,0,0,0,1,1,1,1,0…;
  - port 1 never waits more than 4 cycles.
- Port 1 alone issues 10 back-to-back reads:
  - p1_ready=1 on all 10 cycles;
  - 10 responses on consecutive cycles, each delayed one cycle.
- Port 0 writes index 1023 and index 1024:
  - first beat: mem_we=1, rsp_err=0;
  - second beat: mem_we=0, rsp_err=1, rdata=0.
- Port 1 write accepted at T, then rst high at T+1:
  - memory holds the data;
  - p1_rsp_valid=0 and ready=0 during reset;
  - after release, simultaneous requests go to port 0.
- Alternating single requests (port 0 at T, port 1 at T+1, port 0 at T+2):
  - each is granted on its own cycle;
  - responses appear on the matching port one cycle later, with no cross-port leakage.

Source files
------------

// File: rtl/dmem_arbiter_if.sv
// One requester port of the data-memory arbiter: request handshake plus the
// registered response that comes back one cycle after acceptance.
interface dmem_arbiter_if;
    logic        valid;
    logic        ready;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        rsp_valid;
    logic        rsp_err;
    logic [31:0] rsp_rdata;

    modport master (
        output valid, we, addr, wdata,
        input  ready, rsp_valid, rsp_err, rsp_rdata
    );

    modport slave (
        input  valid, we, addr, wdata,
        output ready, rsp_valid, rsp_err, rsp_rdata
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter with bounded bursts in front of a single-port,
// word-indexed data memory; out-of-range beats get an error response.
module dmem_arbiter #(
    parameter int unsigned DEPTH     = 1024,
    parameter int unsigned MAX_BURST = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    dmem_arbiter_if.slave        p0,
    dmem_arbiter_if.slave        p1,
    output logic                 mem_we,
    output logic [31:0]          mem_addr,
    output logic [31:0]          mem_wd,
    input  logic [31:0]          mem_rd
);
    localparam int CW = $clog2(MAX_BURST + 1);

    typedef enum logic [1:0] {IDLE, OWN0, OWN1} owner_t;

    owner_t        owner_q;
    logic [CW-1:0] cnt_q;
    logic          rr_q;
    logic          rsp_valid0_q, rsp_valid1_q;
    logic          rsp_err0_q, rsp_err1_q;
    logic [31:0]   rsp_rdata0_q, rsp_rdata1_q;

    logic          gnt0, gnt1;
    logic          acc;
    logic          sel_we;
    logic          in_range;
    logic          burst_open;
    logic [31:0]   rdata_d;

    assign burst_open = (cnt_q < CW'(MAX_BURST));

    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (!rst) begin
            unique case (owner_q)
                IDLE: begin
                    if (p0.valid && p1.valid) begin
                        gnt0 = !rr_q;
                        gnt1 = rr_q;
                    end else begin
                        gnt0 = p0.valid;
                        gnt1 = p1.valid;
                    end
                end
                OWN0: begin
                    if (p0.valid && (burst_open || !p1.valid)) gnt0 = 1'b1;
                    else if (p1.valid)                         gnt1 = 1'b1;
                end
                OWN1: begin
                    if (p1.valid && (burst_open || !p0.valid)) gnt1 = 1'b1;
                    else if (p0.valid)                         gnt0 = 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Grants are only ever raised for a valid port, so a grant is an accept.
    assign acc      = gnt0 | gnt1;
    assign p0.ready = gnt0;
    assign p1.ready = gnt1;

    assign mem_addr = gnt1 ? p1.addr  : (gnt0 ? p0.addr  : 32'h0);
    assign mem_wd   = gnt1 ? p1.wdata : (gnt0 ? p0.wdata : 32'h0);
    assign sel_we   = gnt1 ? p1.we    : (gnt0 ? p0.we    : 1'b0);
    assign in_range = (mem_addr < 32'(DEPTH));
    assign mem_we   = acc & sel_we & in_range;
    assign rdata_d  = (!sel_we && in_range) ? mem_rd : 32'h0;

    always_ff @(posedge clk) begin
        if (rst) begin
            owner_q      <= IDLE;
            cnt_q        <= '0;
            rr_q         <= 1'b0;
            rsp_valid0_q <= 1'b0;
            rsp_valid1_q <= 1'b0;
            rsp_err0_q   <= 1'b0;
            rsp_err1_q   <= 1'b0;
            rsp_rdata0_q <= 32'h0;
            rsp_rdata1_q <= 32'h0;
        end else begin
            if (gnt0) begin
                owner_q <= OWN0;
                cnt_q   <= (owner_q != OWN0) ? CW'(1) : (burst_open ? cnt_q + CW'(1) : cnt_q);
                rr_q    <= 1'b1;
            end else if (gnt1) begin
                owner_q <= OWN1;
                cnt_q   <= (owner_q != OWN1) ? CW'(1) : (burst_open ? cnt_q + CW'(1) : cnt_q);
                rr_q    <= 1'b0;
            end else begin
                owner_q <= IDLE;
                cnt_q   <= '0;
            end
            rsp_valid0_q <= gnt0;
            rsp_valid1_q <= gnt1;
            rsp_err0_q   <= gnt0 & !in_range;
            rsp_err1_q   <= gnt1 & !in_range;
            rsp_rdata0_q <= gnt0 ? rdata_d : 32'h0;
            rsp_rdata1_q <= gnt1 ? rdata_d : 32'h0;
        end
    end

    // A response still in flight when reset rises is dropped, not presented.
    assign p0.rsp_valid = rsp_valid0_q & !rst;
    assign p1.rsp_valid = rsp_valid1_q & !rst;
    assign p0.rsp_err   = rsp_err0_q;
    assign p1.rsp_err   = rsp_err1_q;
    assign p0.rsp_rdata = rsp_rdata0_q;
    assign p1.rsp_rdata = rsp_rdata1_q;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: stimulus pushes expected responses into
// per-port queues, a monitor pops and compares when rsp_valid appears.
module tb_dmem_arbiter;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_init = 1'b1;
    logic        mem_we;
    logic [31:0] mem_addr, mem_wd, mem_rd;
    logic [31:0] tmem [0:1023];
    int          cyc = 0;
    int          n_tests = 0;
    int          n_fail = 0;

    typedef struct {
        int          stamp;
        logic        err;
        logic [31:0] rd;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    exp_t e0, e1;

    dmem_arbiter_if p0if ();
    dmem_arbiter_if p1if ();

    dmem_arbiter #(.DEPTH(1024), .MAX_BURST(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .p0       (p0if),
        .p1       (p1if),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wd   (mem_wd),
        .mem_rd   (mem_rd)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 1024; i++) tmem[i] <= 32'h5A000000 + 32'(i);
        end else if (mem_we && mem_addr < 32'd1024) begin
            tmem[mem_addr[9:0]] <= mem_wd;
        end
    end
    assign mem_rd = (mem_addr < 32'd1024) ? tmem[mem_addr[9:0]] : 32'h0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (p0if.rsp_valid === 1'b1) begin
            if (q0.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL p0_spurious_rsp: got rsp_valid=1 expected 0 (cycle %0d)", cyc);
            end else begin
                e0 = q0.pop_front();
                check("p0_rsp_cycle", 32'(cyc), 32'(e0.stamp));
                check("p0_rsp_err", {31'h0, p0if.rsp_err}, {31'h0, e0.err});
                check("p0_rsp_rdata", p0if.rsp_rdata, e0.rd);
            end
        end
        if (p1if.rsp_valid === 1'b1) begin
            if (q1.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL p1_spurious_rsp: got rsp_valid=1 expected 0 (cycle %0d)", cyc);
            end else begin
                e1 = q1.pop_front();
                check("p1_rsp_cycle", 32'(cyc), 32'(e1.stamp));
                check("p1_rsp_err", {31'h0, p1if.rsp_err}, {31'h0, e1.err});
                check("p1_rsp_rdata", p1if.rsp_rdata, e1.rd);
            end
        end
    end

    // eg: expected grant (0 none, 1 port 0, 2 port 1)
    task automatic beat(input logic v0, input logic w0, input logic [31:0] a0, input logic [31:0] d0,
                        input logic v1, input logic w1, input logic [31:0] a1, input logic [31:0] d1,
                        input int eg, input logic ewe, input logic eerr, input logic [31:0] erd,
                        input string tag);
        logic [31:0] eaddr;
        @(negedge clk);
        p0if.valid = v0; p0if.we = w0; p0if.addr = a0; p0if.wdata = d0;
        p1if.valid = v1; p1if.we = w1; p1if.addr = a1; p1if.wdata = d1;
        #1;
        eaddr = (eg == 1) ? a0 : ((eg == 2) ? a1 : 32'h0);
        check({tag, "_p0_ready"}, {31'h0, p0if.ready}, {31'h0, eg == 1});
        check({tag, "_p1_ready"}, {31'h0, p1if.ready}, {31'h0, eg == 2});
        check({tag, "_mem_we"}, {31'h0, mem_we}, {31'h0, ewe});
        check({tag, "_mem_addr"}, mem_addr, eaddr);
        if (eg == 1) q0.push_back('{cyc + 1, eerr, erd});
        if (eg == 2) q1.push_back('{cyc + 1, eerr, erd});
    endtask

    task automatic idle();
        beat(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, "idle");
    endtask

    int pat[10] = '{1, 1, 1, 1, 2, 2, 2, 2, 1, 1};

    initial begin
        p0if.valid = 1; p0if.we = 1; p0if.addr = 32'd5; p0if.wdata = 32'h1;
        p1if.valid = 1; p1if.we = 1; p1if.addr = 32'd6; p1if.wdata = 32'h2;
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        check("rst_p0_ready", {31'h0, p0if.ready}, 32'h0);
        check("rst_p1_ready", {31'h0, p1if.ready}, 32'h0);
        check("rst_mem_we", {31'h0, mem_we}, 32'h0);
        check("rst_p0_rsp_valid", {31'h0, p0if.rsp_valid}, 32'h0);
        check("rst_p1_rsp_valid", {31'h0, p1if.rsp_valid}, 32'h0);
        rst = 0;
        mem_init = 0;
        p0if.valid = 0;
        p1if.valid = 0;

        beat(1, 1, 32'd28, 32'h20, 0, 0, 0, 0, 1, 1, 0, 32'h0, "wr28");
        beat(1, 0, 32'd28, 32'h0, 0, 0, 0, 0, 1, 0, 0, 32'h20, "rd28");
        idle();

        for (int i = 0; i < 10; i++)
            beat(0, 0, 0, 0, 1, 0, 32'd100 + 32'(i), 0, 2, 0, 0, 32'h5A000064 + 32'(i), "p1_stream");
        idle();

        for (int i = 0; i < 10; i++)
            beat(1, 0, 32'd200, 0, 1, 0, 32'd300, 0, pat[i], 0, 0,
                 (pat[i] == 1) ? 32'h5A0000C8 : 32'h5A00012C, "burst");
        idle();

        beat(1, 1, 32'd1023, 32'hDEADBEEF, 0, 0, 0, 0, 1, 1, 0, 32'h0, "wr1023");
        beat(1, 1, 32'd1024, 32'h11111111, 0, 0, 0, 0, 1, 0, 1, 32'h0, "wr1024");
        beat(0, 0, 0, 0, 1, 0, 32'hFFFFFFFF, 0, 2, 0, 1, 32'h0, "rd_ffff");
        beat(1, 0, 32'd1023, 0, 0, 0, 0, 0, 1, 0, 0, 32'hDEADBEEF, "rd1023");
        beat(1, 0, 32'd1024, 0, 0, 0, 0, 0, 1, 0, 1, 32'h0, "rd1024");
        idle();
        check("mem_1023", tmem[1023], 32'hDEADBEEF);

        beat(0, 0, 0, 0, 1, 1, 32'd50, 32'h12345678, 2, 1, 0, 32'h0, "wr50");
        // reset follows immediately, so this response must never appear
        void'(q1.pop_back());
        @(negedge clk);
        rst = 1;
        p0if.valid = 1; p0if.we = 1; p0if.addr = 32'd7;
        p1if.valid = 1; p1if.we = 1; p1if.addr = 32'd8;
        #1;
        check("rst2_p0_ready", {31'h0, p0if.ready}, 32'h0);
        check("rst2_p1_ready", {31'h0, p1if.ready}, 32'h0);
        check("rst2_mem_we", {31'h0, mem_we}, 32'h0);
        check("rst2_p1_rsp_valid", {31'h0, p1if.rsp_valid}, 32'h0);
        @(negedge clk);
        rst = 0;
        p0if.valid = 0;
        p1if.valid = 0;
        check("mem_50", tmem[50], 32'h12345678);
        beat(1, 0, 32'd200, 0, 1, 0, 32'd50, 0, 1, 0, 0, 32'h5A0000C8, "post_rst_both");
        beat(0, 0, 0, 0, 1, 0, 32'd50, 0, 2, 0, 0, 32'h12345678, "rd50");
        idle();

        beat(1, 0, 32'd101, 0, 0, 0, 0, 0, 1, 0, 0, 32'h5A000065, "alt0");
        beat(0, 0, 0, 0, 1, 0, 32'd102, 0, 2, 0, 0, 32'h5A000066, "alt1");
        beat(1, 1, 32'd60, 32'hCAFEF00D, 0, 0, 0, 0, 1, 1, 0, 32'h0, "alt2");
        repeat (3) idle();
        check("mem_60", tmem[60], 32'hCAFEF00D);
        check("q0_drained", 32'(q0.size()), 32'h0);
        check("q1_drained", 32'(q1.size()), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
